// File: rtl/bfly_unit_if.sv
// rtl/bfly_unit_if.sv - butterfly stage lane bundle with producer/consumer modports
interface bfly_unit_if #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16
);
  logic                    bfly_valid;
  logic signed [WIDTH-1:0] din_re        [0:NUM_PAIR-1];
  logic signed [WIDTH-1:0] din_im        [0:NUM_PAIR-1];
  logic signed [WIDTH-1:0] shift_data_re [0:NUM_PAIR-1];
  logic signed [WIDTH-1:0] shift_data_im [0:NUM_PAIR-1];
  logic signed [WIDTH:0]   bfly_sum_re   [0:NUM_PAIR-1];
  logic signed [WIDTH:0]   bfly_sum_im   [0:NUM_PAIR-1];
  logic signed [WIDTH:0]   bfly_diff_re  [0:NUM_PAIR-1];
  logic signed [WIDTH:0]   bfly_diff_im  [0:NUM_PAIR-1];
  logic                    twiddle_valid;

  modport master (
    output bfly_valid, din_re, din_im, shift_data_re, shift_data_im,
    input  bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im, twiddle_valid
  );

  modport slave (
    input  bfly_valid, din_re, din_im, shift_data_re, shift_data_im,
    output bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im, twiddle_valid
  );
endinterface

// File: rtl/bfly_unit.sv
// rtl/bfly_unit.sv - radix-2 butterfly stage, NUM_PAIR lanes, full-precision registered sum/diff
module bfly_unit #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16
) (
  input  logic        clk,
  input  logic        rstn,
  bfly_unit_if.slave  bif
);

  logic signed [WIDTH:0] w_sum_re  [0:NUM_PAIR-1];
  logic signed [WIDTH:0] w_sum_im  [0:NUM_PAIR-1];
  logic signed [WIDTH:0] w_diff_re [0:NUM_PAIR-1];
  logic signed [WIDTH:0] w_diff_im [0:NUM_PAIR-1];

  logic signed [WIDTH:0] r_sum_re  [0:NUM_PAIR-1];
  logic signed [WIDTH:0] r_sum_im  [0:NUM_PAIR-1];
  logic signed [WIDTH:0] r_diff_re [0:NUM_PAIR-1];
  logic signed [WIDTH:0] r_diff_im [0:NUM_PAIR-1];
  logic                  r_twiddle_valid;

  // Per-lane butterfly; one extra bit of sign extension absorbs the full range, no wrap possible
  always_comb begin
    for (int i = 0; i < NUM_PAIR; i++) begin
      w_sum_re[i]  = {bif.din_re[i][WIDTH-1], bif.din_re[i]}
                   + {bif.shift_data_re[i][WIDTH-1], bif.shift_data_re[i]};
      w_sum_im[i]  = {bif.din_im[i][WIDTH-1], bif.din_im[i]}
                   + {bif.shift_data_im[i][WIDTH-1], bif.shift_data_im[i]};
      w_diff_re[i] = {bif.din_re[i][WIDTH-1], bif.din_re[i]}
                   - {bif.shift_data_re[i][WIDTH-1], bif.shift_data_re[i]};
      w_diff_im[i] = {bif.din_im[i][WIDTH-1], bif.din_im[i]}
                   - {bif.shift_data_im[i][WIDTH-1], bif.shift_data_im[i]};
    end
  end

  // Result registers load only on valid cycles and hold otherwise; valid is delayed one cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_twiddle_valid <= 1'b0;
      for (int i = 0; i < NUM_PAIR; i++) begin
        r_sum_re[i]  <= '0;
        r_sum_im[i]  <= '0;
        r_diff_re[i] <= '0;
        r_diff_im[i] <= '0;
      end
    end else begin
      r_twiddle_valid <= bif.bfly_valid;
      if (bif.bfly_valid) begin
        for (int i = 0; i < NUM_PAIR; i++) begin
          r_sum_re[i]  <= w_sum_re[i];
          r_sum_im[i]  <= w_sum_im[i];
          r_diff_re[i] <= w_diff_re[i];
          r_diff_im[i] <= w_diff_im[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PAIR; g++) begin : g_lane_out
    assign bif.bfly_sum_re[g]  = r_sum_re[g];
    assign bif.bfly_sum_im[g]  = r_sum_im[g];
    assign bif.bfly_diff_re[g] = r_diff_re[g];
    assign bif.bfly_diff_im[g] = r_diff_im[g];
  end

  assign bif.twiddle_valid = r_twiddle_valid;

endmodule

// File: tb/tb_bfly_unit.sv
// tb/tb_bfly_unit.sv - directed self-checking bench for bfly_unit
module tb_bfly_unit;
  localparam int W = 12;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;

  bfly_unit_if #(.WIDTH(W), .NUM_PAIR(N)) bif ();

  bfly_unit #(.WIDTH(W), .NUM_PAIR(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bif  (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int dr, input int di, input int sr, input int si,
                       input int lane_step);
    bif.bfly_valid = v;
    for (int i = 0; i < N; i++) begin
      bif.din_re[i]        = W'(dr + lane_step * i);
      bif.din_im[i]        = W'(di + lane_step * i);
      bif.shift_data_re[i] = W'(sr + lane_step * i);
      bif.shift_data_im[i] = W'(si + lane_step * i);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 123, -456, 789, -1000, 3);
    step();
    for (int i = 0; i < N; i++) begin
      checks++; if (bif.bfly_sum_re[i] !== 13'd0) begin failures++; $display("FAIL reset sum_re lane %0d got %0d want 0", i, bif.bfly_sum_re[i]); end
      checks++; if (bif.bfly_sum_im[i] !== 13'd0) begin failures++; $display("FAIL reset sum_im lane %0d got %0d want 0", i, bif.bfly_sum_im[i]); end
      checks++; if (bif.bfly_diff_re[i] !== 13'd0) begin failures++; $display("FAIL reset diff_re lane %0d got %0d want 0", i, bif.bfly_diff_re[i]); end
      checks++; if (bif.bfly_diff_im[i] !== 13'd0) begin failures++; $display("FAIL reset diff_im lane %0d got %0d want 0", i, bif.bfly_diff_im[i]); end
    end
    checks++; if (bif.twiddle_valid !== 1'b0) begin failures++; $display("FAIL reset twiddle_valid got %b want 0", bif.twiddle_valid); end
    rstn = 1'b1;
  endtask

  task automatic test_idle_ignored();
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 10*c, 10*c + 100, 10*c + 200, 10*c + 300, 1);
      step();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bif.bfly_sum_re[i] !== 13'd0 || bif.bfly_sum_im[i] !== 13'd0 ||
            bif.bfly_diff_re[i] !== 13'd0 || bif.bfly_diff_im[i] !== 13'd0) begin
          failures++;
          $display("FAIL idle lane %0d cycle %0d got %0d/%0d/%0d/%0d want 0/0/0/0", i, c,
                   bif.bfly_sum_re[i], bif.bfly_sum_im[i], bif.bfly_diff_re[i], bif.bfly_diff_im[i]);
        end
      end
      checks++; if (bif.twiddle_valid !== 1'b0) begin failures++; $display("FAIL idle twiddle_valid cycle %0d got %b want 0", c, bif.twiddle_valid); end
    end
  endtask

  task automatic test_burst(input string name, input int dr0, input int di0, input int sr0,
                            input int si0, input int sum_re0, input int sum_im0);
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, dr0 + c, di0 + c, sr0 + c, si0 + c, 0);
      step();
      for (int i = 0; i < N; i++) begin
        checks++; if (bif.bfly_sum_re[i] !== 13'(sum_re0 + 2*c)) begin failures++; $display("FAIL %s sum_re lane %0d cycle %0d got %0d want %0d", name, i, c, bif.bfly_sum_re[i], sum_re0 + 2*c); end
        checks++; if (bif.bfly_sum_im[i] !== 13'(sum_im0 + 2*c)) begin failures++; $display("FAIL %s sum_im lane %0d cycle %0d got %0d want %0d", name, i, c, bif.bfly_sum_im[i], sum_im0 + 2*c); end
        checks++; if (bif.bfly_diff_re[i] !== -13'sd10) begin failures++; $display("FAIL %s diff_re lane %0d cycle %0d got %0d want -10", name, i, c, bif.bfly_diff_re[i]); end
        checks++; if (bif.bfly_diff_im[i] !== -13'sd100) begin failures++; $display("FAIL %s diff_im lane %0d cycle %0d got %0d want -100", name, i, c, bif.bfly_diff_im[i]); end
      end
      checks++; if (bif.twiddle_valid !== 1'b1) begin failures++; $display("FAIL %s twiddle_valid cycle %0d got %b want 1", name, c, bif.twiddle_valid); end
    end
  endtask

  task automatic test_hold_gap(input int n_cycles, input int hold_sum_re, input int hold_sum_im);
    for (int c = 0; c < n_cycles; c++) begin
      drive(1'b0, 50 + c, 150 + c, 60 + c, 250 + c, 0);
      step();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bif.bfly_sum_re[i] !== 13'(hold_sum_re) || bif.bfly_sum_im[i] !== 13'(hold_sum_im) ||
            bif.bfly_diff_re[i] !== -13'sd10 || bif.bfly_diff_im[i] !== -13'sd100) begin
          failures++;
          $display("FAIL hold lane %0d cycle %0d got %0d/%0d/%0d/%0d want %0d/%0d/-10/-100", i, c,
                   bif.bfly_sum_re[i], bif.bfly_sum_im[i], bif.bfly_diff_re[i], bif.bfly_diff_im[i],
                   hold_sum_re, hold_sum_im);
        end
      end
      checks++; if (bif.twiddle_valid !== 1'b0) begin failures++; $display("FAIL hold twiddle_valid cycle %0d got %b want 0", c, bif.twiddle_valid); end
    end
  endtask

  task automatic test_extremes();
    // most negative plus most negative
    drive(1'b1, -2048, -2048, -2048, -2048, 0);
    step();
    checks++; if (bif.bfly_sum_re[0] !== -13'sd4096) begin failures++; $display("FAIL ext_neg sum_re got %0d want -4096", bif.bfly_sum_re[0]); end
    checks++; if (bif.bfly_sum_im[N-1] !== -13'sd4096) begin failures++; $display("FAIL ext_neg sum_im got %0d want -4096", bif.bfly_sum_im[N-1]); end
    checks++; if (bif.bfly_diff_re[5] !== 13'sd0) begin failures++; $display("FAIL ext_neg diff_re got %0d want 0", bif.bfly_diff_re[5]); end
    checks++; if (bif.bfly_diff_im[9] !== 13'sd0) begin failures++; $display("FAIL ext_neg diff_im got %0d want 0", bif.bfly_diff_im[9]); end
    // max positive against most negative, imaginary with operands swapped
    drive(1'b1, 2047, -2048, -2048, 2047, 0);
    step();
    checks++; if (bif.bfly_sum_re[3] !== -13'sd1) begin failures++; $display("FAIL ext_pos sum_re got %0d want -1", bif.bfly_sum_re[3]); end
    checks++; if (bif.bfly_diff_re[3] !== 13'sd4095) begin failures++; $display("FAIL ext_pos diff_re got %0d want 4095", bif.bfly_diff_re[3]); end
    checks++; if (bif.bfly_sum_im[12] !== -13'sd1) begin failures++; $display("FAIL ext_pos sum_im got %0d want -1", bif.bfly_sum_im[12]); end
    checks++; if (bif.bfly_diff_im[12] !== -13'sd4095) begin failures++; $display("FAIL ext_pos diff_im got %0d want -4095", bif.bfly_diff_im[12]); end
    checks++; if (bif.twiddle_valid !== 1'b1) begin failures++; $display("FAIL ext twiddle_valid got %b want 1", bif.twiddle_valid); end
  endtask

  task automatic test_lane_independence();
    bif.bfly_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      bif.din_re[i]        = W'(37*i - 300);
      bif.din_im[i]        = W'(-11*i);
      bif.shift_data_re[i] = W'(5*i);
      bif.shift_data_im[i] = W'(200 - 23*i);
    end
    step();
    for (int i = 0; i < N; i++) begin
      checks++; if (bif.bfly_sum_re[i] !== 13'(42*i - 300)) begin failures++; $display("FAIL lanes sum_re lane %0d got %0d want %0d", i, bif.bfly_sum_re[i], 42*i - 300); end
      checks++; if (bif.bfly_sum_im[i] !== 13'(200 - 34*i)) begin failures++; $display("FAIL lanes sum_im lane %0d got %0d want %0d", i, bif.bfly_sum_im[i], 200 - 34*i); end
      checks++; if (bif.bfly_diff_re[i] !== 13'(32*i - 300)) begin failures++; $display("FAIL lanes diff_re lane %0d got %0d want %0d", i, bif.bfly_diff_re[i], 32*i - 300); end
      checks++; if (bif.bfly_diff_im[i] !== 13'(12*i - 200)) begin failures++; $display("FAIL lanes diff_im lane %0d got %0d want %0d", i, bif.bfly_diff_im[i], 12*i - 200); end
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(1'b1, 100, 200, 300, 400, 0);
    rstn = 1'b0;
    step();
    checks++; if (bif.bfly_sum_re[0] !== 13'd0 || bif.bfly_diff_im[N-1] !== 13'd0) begin failures++; $display("FAIL midrst outputs got %0d/%0d want 0/0", bif.bfly_sum_re[0], bif.bfly_diff_im[N-1]); end
    checks++; if (bif.twiddle_valid !== 1'b0) begin failures++; $display("FAIL midrst twiddle_valid got %b want 0", bif.twiddle_valid); end
    rstn = 1'b1;
    step();
    checks++; if (bif.bfly_sum_re[7] !== 13'sd400 || bif.bfly_sum_im[7] !== 13'sd600) begin failures++; $display("FAIL midrst resume sum got %0d/%0d want 400/600", bif.bfly_sum_re[7], bif.bfly_sum_im[7]); end
    checks++; if (bif.bfly_diff_re[7] !== -13'sd200 || bif.bfly_diff_im[7] !== -13'sd200) begin failures++; $display("FAIL midrst resume diff got %0d/%0d want -200/-200", bif.bfly_diff_re[7], bif.bfly_diff_im[7]); end
    checks++; if (bif.twiddle_valid !== 1'b1) begin failures++; $display("FAIL midrst resume twiddle_valid got %b want 1", bif.twiddle_valid); end
    drive(1'b0, 0, 0, 0, 0, 0);
    step();
    checks++; if (bif.twiddle_valid !== 1'b0) begin failures++; $display("FAIL final twiddle_valid got %b want 0", bif.twiddle_valid); end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_burst("burst_a", 30, 130, 40, 230, 70, 360);
    test_hold_gap(16, 100, 390);
    test_burst("burst_b", 70, 170, 80, 270, 150, 440);
    test_hold_gap(1, 180, 470);
    test_extremes();
    test_burst("back_to_back", 70, 170, 80, 270, 150, 440);
    test_lane_independence();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
